// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - shared types and constants for the SDRAM command-port arbiter
package sdram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CPU   = 2'b01,
    SPART = 2'b10,
    AUD   = 2'b11
  } busy_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_WAIT_WR,
    S_DONE
  } arb_state_e;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;

  // Encoding 11 is reserved and behaves like no request.
  function automatic logic cpu_op_active(input logic [1:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/arb_prio_sel.sv
// rtl/arb_prio_sel.sv - combinational winner select: aged requesters first, then Audio > CPU > SPART
module arb_prio_sel
  import sdram_arb_pkg::*;
(
  input  logic  aud_req,
  input  logic  cpu_req,
  input  logic  spart_req,
  input  logic  aud_aged,
  input  logic  cpu_aged,
  input  logic  spart_aged,
  output busy_e owner
);

  logic aud_hi;
  logic cpu_hi;
  logic spart_hi;

  always_comb begin
    aud_hi   = aud_req & aud_aged;
    cpu_hi   = cpu_req & cpu_aged;
    spart_hi = spart_req & spart_aged;
    owner    = IDLE;
    if (aud_hi | cpu_hi | spart_hi) begin
      if (aud_hi)      owner = AUD;
      else if (cpu_hi) owner = CPU;
      else             owner = SPART;
    end else if (aud_req) begin
      owner = AUD;
    end else if (cpu_req) begin
      owner = CPU;
    end else if (spart_req) begin
      owner = SPART;
    end
  end

endmodule

// File: rtl/sdram_arbiter.sv
// rtl/sdram_arbiter.sv - shares the SDRAM command port among CPU, SPART and Audio
// Optional aging promotion is enabled by defining SDRAM_ARB_AGING_EN.
module sdram_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int MAX_WAIT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  cpu_op,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  input  logic        spart_req,
  input  logic        spart_we,
  input  logic [31:0] spart_addr,
  input  logic [31:0] spart_wdata,
  output logic [31:0] spart_rdata,
  output logic        spart_done,
  input  logic        aud_req,
  input  logic [31:0] aud_addr,
  output logic [31:0] aud_rdata,
  output logic        aud_done,
  output logic        sd_cmd_valid,
  input  logic        sd_cmd_ready,
  output logic        sd_cmd_we,
  output logic [31:0] sd_cmd_addr,
  output logic [31:0] sd_cmd_wdata,
  input  logic        sd_rd_valid,
  input  logic [31:0] sd_rd_data,
  input  logic        sd_wr_ack,
  output logic [1:0]  mem_busy
);

  if (MAX_WAIT < 2 || MAX_WAIT > 255) begin : g_bad_max_wait
    $error("sdram_arbiter: MAX_WAIT must be within 2..255");
  end

  arb_state_e state;
  busy_e      owner;
  busy_e      winner;
  logic       cpu_act;
  logic [2:0] aged_vec;

  assign cpu_act  = cpu_op_active(cpu_op);
  assign mem_busy = owner;

  arb_prio_sel u_prio_sel (
    .aud_req    (aud_req),
    .cpu_req    (cpu_act),
    .spart_req  (spart_req),
    .aud_aged   (aged_vec[2]),
    .cpu_aged   (aged_vec[1]),
    .spart_aged (aged_vec[0]),
    .owner      (winner)
  );

`ifdef SDRAM_ARB_AGING_EN
  localparam logic [7:0] MAX_W = 8'(MAX_WAIT);

  logic [2:0] req_vec;
  logic [2:0] grant_vec;

  assign req_vec   = {aud_req, cpu_act, spart_req};
  assign grant_vec = (state == S_IDLE) ?
                     {winner == AUD, winner == CPU, winner == SPART} : 3'b000;

  // A requester only ages in IDLE cycles where it is active and somebody else wins.
  for (genvar i = 0; i < 3; i++) begin : g_age
    logic [7:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        wait_cnt <= '0;
      end else if (!req_vec[i] || grant_vec[i]) begin
        wait_cnt <= '0;
      end else if (state == S_IDLE && wait_cnt != MAX_W) begin
        wait_cnt <= wait_cnt + 8'd1;
      end
    end

    assign aged_vec[i] = (wait_cnt == MAX_W);
  end
`else
  assign aged_vec = 3'b000;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      owner        <= IDLE;
      sd_cmd_valid <= 1'b0;
      sd_cmd_we    <= 1'b0;
      sd_cmd_addr  <= '0;
      sd_cmd_wdata <= '0;
      cpu_rdata    <= '0;
      spart_rdata  <= '0;
      aud_rdata    <= '0;
      cpu_done     <= 1'b0;
      spart_done   <= 1'b0;
      aud_done     <= 1'b0;
    end else begin
      cpu_done   <= 1'b0;
      spart_done <= 1'b0;
      aud_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (winner != IDLE) begin
            owner        <= winner;
            sd_cmd_valid <= 1'b1;
            state        <= S_ISSUE;
            case (winner)
              AUD: begin
                sd_cmd_we    <= 1'b0;
                sd_cmd_addr  <= aud_addr;
                sd_cmd_wdata <= '0;
              end
              CPU: begin
                sd_cmd_we    <= (cpu_op == OP_WR);
                sd_cmd_addr  <= cpu_addr;
                sd_cmd_wdata <= cpu_wdata;
              end
              default: begin
                sd_cmd_we    <= spart_we;
                sd_cmd_addr  <= spart_addr;
                sd_cmd_wdata <= spart_wdata;
              end
            endcase
          end
        end
        S_ISSUE: begin
          if (sd_cmd_ready) begin
            sd_cmd_valid <= 1'b0;
            state        <= sd_cmd_we ? S_WAIT_WR : S_WAIT_RD;
          end
        end
        S_WAIT_RD: begin
          if (sd_rd_valid) begin
            state <= S_DONE;
            case (owner)
              AUD:     begin aud_rdata   <= sd_rd_data; aud_done   <= 1'b1; end
              CPU:     begin cpu_rdata   <= sd_rd_data; cpu_done   <= 1'b1; end
              SPART:   begin spart_rdata <= sd_rd_data; spart_done <= 1'b1; end
              default: ;
            endcase
          end
        end
        S_WAIT_WR: begin
          if (sd_wr_ack) begin
            state      <= S_DONE;
            aud_done   <= (owner == AUD);
            cpu_done   <= (owner == CPU);
            spart_done <= (owner == SPART);
          end
        end
        S_DONE: begin
          owner <= IDLE;
          state <= S_IDLE;
        end
        default: begin
          owner        <= IDLE;
          sd_cmd_valid <= 1'b0;
          state        <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb/tb_sdram_arbiter.sv - scoreboard bench for sdram_arbiter (honours SDRAM_ARB_AGING_EN)
module tb_sdram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cpu_op = 2'b00;
  logic [31:0] cpu_addr = '0;
  logic [31:0] cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_done;
  logic        spart_req = 1'b0;
  logic        spart_we = 1'b0;
  logic [31:0] spart_addr = '0;
  logic [31:0] spart_wdata = '0;
  logic [31:0] spart_rdata;
  logic        spart_done;
  logic        aud_req = 1'b0;
  logic [31:0] aud_addr = '0;
  logic [31:0] aud_rdata;
  logic        aud_done;
  logic        sd_cmd_valid;
  logic        sd_cmd_ready = 1'b0;
  logic        sd_cmd_we;
  logic [31:0] sd_cmd_addr;
  logic [31:0] sd_cmd_wdata;
  logic        sd_rd_valid = 1'b0;
  logic [31:0] sd_rd_data = '0;
  logic        sd_wr_ack = 1'b0;
  logic [1:0]  mem_busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [1:0]  owner;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } cmd_t;

  typedef struct {
    logic [1:0]  owner;
    logic [31:0] rdata;
  } done_t;

  cmd_t  exp_cmd_q[$];
  done_t exp_done_q[$];

  always #5 clk = ~clk;

  sdram_arbiter #(.MAX_WAIT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_op       (cpu_op),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .cpu_rdata    (cpu_rdata),
    .cpu_done     (cpu_done),
    .spart_req    (spart_req),
    .spart_we     (spart_we),
    .spart_addr   (spart_addr),
    .spart_wdata  (spart_wdata),
    .spart_rdata  (spart_rdata),
    .spart_done   (spart_done),
    .aud_req      (aud_req),
    .aud_addr     (aud_addr),
    .aud_rdata    (aud_rdata),
    .aud_done     (aud_done),
    .sd_cmd_valid (sd_cmd_valid),
    .sd_cmd_ready (sd_cmd_ready),
    .sd_cmd_we    (sd_cmd_we),
    .sd_cmd_addr  (sd_cmd_addr),
    .sd_cmd_wdata (sd_cmd_wdata),
    .sd_rd_valid  (sd_rd_valid),
    .sd_rd_data   (sd_rd_data),
    .sd_wr_ack    (sd_wr_ack),
    .mem_busy     (mem_busy)
  );

  function automatic logic [31:0] rd_model(input logic [31:0] a);
    return {a[15:0], ~a[15:0]};
  endfunction

  function automatic logic [31:0] rdata_of(input logic [1:0] who);
    return (who == 2'b11) ? aud_rdata : (who == 2'b01) ? cpu_rdata : spart_rdata;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({sd_cmd_valid, sd_cmd_we, mem_busy, cpu_done, spart_done, aud_done} !== 7'd0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 0", {sd_cmd_valid, sd_cmd_we, mem_busy, cpu_done, spart_done, aud_done});
    end
    checks++;
    if ((cpu_rdata | spart_rdata | aud_rdata | sd_cmd_addr | sd_cmd_wdata) !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: got nonzero data outputs, want 0");
    end
    rst_n = 1'b1;
    @(negedge clk);
    sd_rd_valid = 1'b1;
    sd_rd_data  = 32'hFFFF_FFFF;
    sd_wr_ack   = 1'b1;
    @(negedge clk);
    sd_rd_valid = 1'b0;
    sd_wr_ack   = 1'b0;
    @(negedge clk);
    checks++;
    if ({mem_busy, cpu_done, spart_done, aud_done, sd_cmd_valid} !== 6'd0 || cpu_rdata !== 32'h0) begin
      errors++;
      $display("FAIL idle_stray_resp: busy=%b dones=%b%b%b valid=%b want all 0",
               mem_busy, cpu_done, spart_done, aud_done, sd_cmd_valid);
    end
  endtask

  task automatic test_cpu_read();
    cmd_t  c;
    done_t d;
    @(negedge clk);
    cpu_op   = 2'b01;
    cpu_addr = 32'h100;
    exp_cmd_q.push_back('{2'b01, 1'b0, 32'h100, 32'h0});
    exp_done_q.push_back('{2'b01, 32'hDEAD_BEEF});
    for (int cyc = 1; cyc <= 7; cyc++) begin
      @(negedge clk);
      sd_cmd_ready = 1'b0;
      sd_rd_valid  = 1'b0;
      checks++;
      if (cpu_done !== (cyc == 5)) begin
        errors++;
        $display("FAIL cpu_rd_done_cycle%0d: got %b want %b", cyc, cpu_done, (cyc == 5));
      end
      checks++;
      if (mem_busy !== ((cyc <= 5) ? 2'b01 : 2'b00)) begin
        errors++;
        $display("FAIL cpu_rd_busy_cycle%0d: got %b", cyc, mem_busy);
      end
      checks++;
      if (sd_cmd_valid !== (cyc == 1)) begin
        errors++;
        $display("FAIL cpu_rd_valid_cycle%0d: got %b want %b", cyc, sd_cmd_valid, (cyc == 1));
      end
      if (sd_cmd_valid && exp_cmd_q.size() != 0) begin
        c = exp_cmd_q.pop_front();
        checks++;
        if (sd_cmd_we !== c.we || sd_cmd_addr !== c.addr) begin
          errors++;
          $display("FAIL cpu_rd_cmd: we=%b addr=%h want we=%b addr=%h", sd_cmd_we, sd_cmd_addr, c.we, c.addr);
        end
        sd_cmd_ready = 1'b1;
      end
      if (cpu_done && exp_done_q.size() != 0) begin
        d = exp_done_q.pop_front();
        checks++;
        if (cpu_rdata !== d.rdata) begin
          errors++;
          $display("FAIL cpu_rd_data: got %h want %h", cpu_rdata, d.rdata);
        end
        cpu_op = 2'b00;
      end
      if (cyc == 4) begin
        sd_rd_valid = 1'b1;
        sd_rd_data  = 32'hDEAD_BEEF;
      end
    end
    checks++;
    if (exp_cmd_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL cpu_rd_pending: cmd=%0d done=%0d want 0", exp_cmd_q.size(), exp_done_q.size());
      exp_cmd_q.delete();
      exp_done_q.delete();
    end
  endtask

  task automatic test_priority();
    cmd_t       c;
    done_t      d;
    logic [1:0] owner;
    logic [1:0] trace[$];
    logic [1:0] seq[$];
    int         gaps[$];
    int         zrun;
    logic       pend = 1'b0;
    logic       pend_we = 1'b0;
    logic [31:0] pend_data = '0;
    @(negedge clk);
    aud_req     = 1'b1;
    aud_addr    = 32'h200;
    cpu_op      = 2'b10;
    cpu_addr    = 32'h300;
    cpu_wdata   = 32'h1111_2222;
    spart_req   = 1'b1;
    spart_we    = 1'b0;
    spart_addr  = 32'h400;
    exp_cmd_q.push_back('{2'b11, 1'b0, 32'h200, 32'h0});
    exp_cmd_q.push_back('{2'b01, 1'b1, 32'h300, 32'h1111_2222});
    exp_cmd_q.push_back('{2'b10, 1'b0, 32'h400, 32'h0});
    exp_done_q.push_back('{2'b11, rd_model(32'h200)});
    exp_done_q.push_back('{2'b01, 32'hDEAD_BEEF});
    exp_done_q.push_back('{2'b10, rd_model(32'h400)});
    for (int cyc = 0; cyc < 80 && exp_done_q.size() != 0; cyc++) begin
      @(negedge clk);
      trace.push_back(mem_busy);
      sd_cmd_ready = 1'b0;
      sd_rd_valid  = 1'b0;
      sd_wr_ack    = 1'b0;
      if (aud_done | cpu_done | spart_done) begin
        owner = aud_done ? 2'b11 : cpu_done ? 2'b01 : 2'b10;
        d = exp_done_q.pop_front();
        checks++;
        if ($countones({aud_done, cpu_done, spart_done}) != 1 || owner !== d.owner || rdata_of(owner) !== d.rdata) begin
          errors++;
          $display("FAIL prio_done: owner=%b rdata=%h want owner=%b rdata=%h", owner, rdata_of(owner), d.owner, d.rdata);
        end
        if (owner == 2'b11) aud_req = 1'b0;
        else if (owner == 2'b01) cpu_op = 2'b00;
        else spart_req = 1'b0;
      end
      if (pend) begin
        if (pend_we) sd_wr_ack = 1'b1;
        else begin
          sd_rd_valid = 1'b1;
          sd_rd_data  = pend_data;
        end
        pend = 1'b0;
      end
      if (sd_cmd_valid) begin
        checks++;
        if (exp_cmd_q.size() == 0) begin
          errors++;
          $display("FAIL prio_cmd: unexpected command busy=%b addr=%h", mem_busy, sd_cmd_addr);
        end else begin
          c = exp_cmd_q.pop_front();
          if (mem_busy !== c.owner || sd_cmd_we !== c.we || sd_cmd_addr !== c.addr ||
              (c.we && sd_cmd_wdata !== c.wdata)) begin
            errors++;
            $display("FAIL prio_cmd: busy=%b we=%b addr=%h wdata=%h want busy=%b we=%b addr=%h wdata=%h",
                     mem_busy, sd_cmd_we, sd_cmd_addr, sd_cmd_wdata, c.owner, c.we, c.addr, c.wdata);
          end
          pend_data = rd_model(c.addr);
        end
        sd_cmd_ready = 1'b1;
        pend    = 1'b1;
        pend_we = sd_cmd_we;
      end
    end
    checks++;
    if (exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL prio_timeout: %0d completions outstanding, want 0", exp_done_q.size());
      exp_done_q.delete();
      exp_cmd_q.delete();
    end
    zrun = 0;
    foreach (trace[i]) begin
      if (trace[i] == 2'b00) zrun++;
      else if (i == 0 || trace[i-1] != trace[i]) begin
        if (seq.size() != 0) gaps.push_back(zrun);
        seq.push_back(trace[i]);
        zrun = 0;
      end
    end
    checks++;
    if (seq.size() != 3 || seq[0] != 2'b11 || seq[1] != 2'b01 || seq[2] != 2'b10 || gaps.size() != 2 ||
        gaps[0] != 1 || gaps[1] != 1) begin
      errors++;
      $display("FAIL prio_busy_seq: got %0d owners, gaps %0d, want 11,01,10 with one idle between", seq.size(), gaps.size());
    end
    @(negedge clk);
  endtask

  task automatic test_ready_stall();
    cmd_t        c;
    done_t       d;
    logic [31:0] keep;
    keep = rd_model(32'h400);
    @(negedge clk);
    spart_req   = 1'b1;
    spart_we    = 1'b1;
    spart_addr  = 32'h500;
    spart_wdata = 32'hCAFE_F00D;
    exp_cmd_q.push_back('{2'b10, 1'b1, 32'h500, 32'hCAFE_F00D});
    exp_done_q.push_back('{2'b10, keep});
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++;
      if ({sd_cmd_valid, sd_cmd_we, mem_busy} !== 4'b1110 || sd_cmd_addr !== 32'h500 ||
          sd_cmd_wdata !== 32'hCAFE_F00D) begin
        errors++;
        $display("FAIL stall_hold%0d: valid=%b we=%b busy=%b addr=%h wdata=%h", i, sd_cmd_valid, sd_cmd_we,
                 mem_busy, sd_cmd_addr, sd_cmd_wdata);
      end
      @(negedge clk);
    end
    c = exp_cmd_q.pop_front();
    checks++;
    if (sd_cmd_valid !== 1'b1 || sd_cmd_addr !== c.addr || sd_cmd_wdata !== c.wdata || sd_cmd_we !== c.we) begin
      errors++;
      $display("FAIL stall_cmd: valid=%b addr=%h wdata=%h want addr=%h wdata=%h", sd_cmd_valid, sd_cmd_addr,
               sd_cmd_wdata, c.addr, c.wdata);
    end
    sd_cmd_ready = 1'b1;
    @(negedge clk);
    sd_cmd_ready = 1'b0;
    sd_rd_valid  = 1'b1;
    sd_rd_data   = 32'h0BAD_0BAD;
    @(negedge clk);
    sd_rd_valid = 1'b0;
    checks++;
    if (spart_done !== 1'b0 || mem_busy !== 2'b10 || spart_rdata !== keep) begin
      errors++;
      $display("FAIL stall_stray_rd: done=%b busy=%b rdata=%h want 0/10/%h", spart_done, mem_busy, spart_rdata, keep);
    end
    sd_wr_ack = 1'b1;
    @(negedge clk);
    sd_wr_ack = 1'b0;
    d = exp_done_q.pop_front();
    checks++;
    if (spart_done !== 1'b1 || spart_rdata !== d.rdata || cpu_done !== 1'b0 || aud_done !== 1'b0) begin
      errors++;
      $display("FAIL spart_wr_done: done=%b rdata=%h want 1/%h", spart_done, spart_rdata, d.rdata);
    end
    spart_req = 1'b0;
    @(negedge clk);
    checks++;
    if (spart_done !== 1'b0 || mem_busy !== 2'b00 || spart_rdata !== keep) begin
      errors++;
      $display("FAIL spart_wr_pulse: done=%b busy=%b rdata=%h want 0/00/%h", spart_done, mem_busy, spart_rdata, keep);
    end
  endtask

  task automatic test_aging();
    logic [1:0]  exp_q[$];
    logic [1:0]  g;
    logic        pend = 1'b0;
    logic [31:0] pend_data = '0;
    logic        last = 1'b0;
    logic        finished = 1'b0;
`ifdef SDRAM_ARB_AGING_EN
    repeat (4) exp_q.push_back(2'b11);
    exp_q.push_back(2'b10);
`else
    repeat (12) exp_q.push_back(2'b11);
`endif
    @(negedge clk);
    aud_req    = 1'b1;
    aud_addr   = 32'h600;
    spart_req  = 1'b1;
    spart_we   = 1'b0;
    spart_addr = 32'h700;
    for (int cyc = 0; cyc < 300 && !finished; cyc++) begin
      @(negedge clk);
      sd_cmd_ready = 1'b0;
      sd_rd_valid  = 1'b0;
      if (aud_done | spart_done | cpu_done) begin
        checks++;
        if (cpu_done || (aud_done && aud_rdata !== rd_model(32'h600)) ||
            (spart_done && spart_rdata !== rd_model(32'h700))) begin
          errors++;
          $display("FAIL age_done: dones=%b%b%b aud=%h spart=%h", aud_done, cpu_done, spart_done, aud_rdata, spart_rdata);
        end
        if (last) begin
          aud_req   = 1'b0;
          spart_req = 1'b0;
          finished  = 1'b1;
        end
      end
      if (pend) begin
        sd_rd_valid = 1'b1;
        sd_rd_data  = pend_data;
        pend = 1'b0;
      end
      if (sd_cmd_valid) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL age_grant: unexpected grant busy=%b", mem_busy);
        end else begin
          g = exp_q.pop_front();
          if (mem_busy !== g) begin
            errors++;
            $display("FAIL age_grant: got busy=%b want %b (%0d grants left)", mem_busy, g, exp_q.size());
          end
        end
        if (exp_q.size() == 0) last = 1'b1;
        sd_cmd_ready = 1'b1;
        pend      = 1'b1;
        pend_data = rd_model(sd_cmd_addr);
      end
    end
    checks++;
    if (!finished) begin
      errors++;
      $display("FAIL age_timeout: %0d grants outstanding", exp_q.size());
      aud_req   = 1'b0;
      spart_req = 1'b0;
    end
    repeat (2) @(negedge clk);
    checks++;
    if (mem_busy !== 2'b00 || sd_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL age_idle: busy=%b valid=%b want 00/0", mem_busy, sd_cmd_valid);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    cpu_op   = 2'b01;
    cpu_addr = 32'h800;
    @(negedge clk);
    checks++;
    if (sd_cmd_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_issue: valid=%b want 1", sd_cmd_valid);
    end
    sd_cmd_ready = 1'b1;
    @(negedge clk);
    sd_cmd_ready = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sd_cmd_valid, sd_cmd_we, mem_busy, cpu_done, spart_done, aud_done} !== 7'd0 ||
        (cpu_rdata | spart_rdata | aud_rdata | sd_cmd_addr | sd_cmd_wdata) !== 32'h0) begin
      errors++;
      $display("FAIL rstmid_outputs: busy=%b valid=%b addr=%h cpu_rdata=%h want all 0", mem_busy, sd_cmd_valid,
               sd_cmd_addr, cpu_rdata);
    end
    cpu_op = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (mem_busy !== 2'b00 || sd_cmd_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_idle: busy=%b valid=%b want 00/0", mem_busy, sd_cmd_valid);
    end
    cpu_op   = 2'b01;
    cpu_addr = 32'h900;
    exp_done_q.push_back('{2'b01, 32'h1234_5678});
    for (int cyc = 1; cyc <= 4; cyc++) begin
      @(negedge clk);
      sd_cmd_ready = 1'b0;
      sd_rd_valid  = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (sd_cmd_valid !== 1'b1 || sd_cmd_addr !== 32'h900 || mem_busy !== 2'b01) begin
          errors++;
          $display("FAIL rstmid_reissue: valid=%b addr=%h busy=%b", sd_cmd_valid, sd_cmd_addr, mem_busy);
        end
        sd_cmd_ready = 1'b1;
      end
      if (cyc == 2) begin
        sd_rd_valid = 1'b1;
        sd_rd_data  = 32'h1234_5678;
      end
      checks++;
      if (cpu_done !== (cyc == 3)) begin
        errors++;
        $display("FAIL rstmid_done_cycle%0d: got %b want %b", cyc, cpu_done, (cyc == 3));
      end
      if (cpu_done && exp_done_q.size() != 0) begin
        checks++;
        if (cpu_rdata !== exp_done_q[0].rdata) begin
          errors++;
          $display("FAIL rstmid_data: got %h want %h", cpu_rdata, exp_done_q[0].rdata);
        end
        void'(exp_done_q.pop_front());
        cpu_op = 2'b00;
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_cpu_read();
    test_priority();
    test_ready_stall();
    test_aging();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
